// File: rtl/add_serial_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// master drives operands and takes results; slave is the adder.
interface add_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] answer;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid,
    output input_a,
    output input_b,
    output sub,
    output carry_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  answer,
    input  carry,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  input_a,
    input  input_b,
    input  sub,
    input  carry_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output answer,
    output carry,
    output overflow
  );
endinterface

// File: rtl/add_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock,
// registered carry, valid/ready on both sides.
module add_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic       iclk,
  input logic       rst,
  add_serial_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] ans_q;
  logic [WIDTH-1:0] ans_nxt;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             sub_q;
  logic             carry_q;
  logic             ovf_q;

  logic [DIGIT:0]   dsum;
  logic [DIGIT-1:0] ds;
  logic             dc;
  logic             cmsb;
  logic             last;
  logic             acc;
  logic             in_ready;
  logic             out_valid;

  assign dsum = {1'b0, a_q[DIGIT-1:0]}
              + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, cy_q};
  assign ds   = dsum[DIGIT-1:0];
  assign dc   = dsum[DIGIT];
  // carry into the top bit of this digit, recovered from its sum bit
  assign cmsb = ds[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign last = (cnt_q == CW'(STEPS - 1));
  assign acc  = bus.in_valid & in_ready;

  assign ans_nxt = (sh_q >> DIGIT)
                 | (WIDTH'(ds) << (WIDTH - DIGIT));

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (acc) state_d = RUN;
      end
      (state_q == RUN): begin
        if (last) state_d = DONE;
      end
      (state_q == DONE): begin
        if (bus.out_ready)
          state_d = bus.in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): in_ready = 1'b1;
      (state_q == DONE): begin
        in_ready  = bus.out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      ans_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (acc) begin
      a_q   <= bus.input_a;
      b_q   <= bus.sub ? ~bus.input_b : bus.input_b;
      cy_q  <= bus.carry_in ^ bus.sub;
      sub_q <= bus.sub;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      sh_q  <= ans_nxt;
      cy_q  <= dc;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        ans_q   <= ans_nxt;
        carry_q <= dc ^ sub_q;
        ovf_q   <= cmsb ^ dc;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.answer    = ans_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial: a DIGIT=2 and a DIGIT=WIDTH
// instance share one stimulus stream.
module tb_add_serial;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] input_a;
  logic [7:0] input_b;
  logic       sub;
  logic       carry_in;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_serial_if #(.WIDTH(8)) bus2 ();
  add_serial_if #(.WIDTH(8)) bus8 ();

  assign bus2.in_valid  = in_valid;
  assign bus2.input_a   = input_a;
  assign bus2.input_b   = input_b;
  assign bus2.sub       = sub;
  assign bus2.carry_in  = carry_in;
  assign bus2.out_ready = out_ready;
  assign bus8.in_valid  = in_valid;
  assign bus8.input_a   = input_a;
  assign bus8.input_b   = input_b;
  assign bus8.sub       = sub;
  assign bus8.carry_in  = carry_in;
  assign bus8.out_ready = out_ready;

  add_serial #(.WIDTH(8), .DIGIT(2)) u_dut (
    .iclk (clk),
    .rst  (rst),
    .bus  (bus2)
  );

  add_serial #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .iclk (clk),
    .rst  (rst),
    .bus  (bus8)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic cin,
                       output logic [7:0] ea, output logic ec,
                       output logic ev);
    logic [8:0] r;
    int sa, sb, sr;
    sa = $signed(a);
    sb = $signed(b);
    if (!s) begin
      r  = {1'b0, a} + {1'b0, b} + 9'(cin);
      sr = sa + sb + int'(cin);
    end else begin
      r  = {1'b0, a} - {1'b0, b} - 9'(cin);
      sr = sa - sb - int'(cin);
    end
    ea = r[7:0];
    ec = r[8];
    ev = (sr > 127) || (sr < -128);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(bus2.out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic cin,
                        input logic [7:0] ea, input logic ec,
                        input logic ev);
    int lat;
    int lat8;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus2.in_ready), 32'd1);
    in_valid = 1'b1;
    input_a  = a;
    input_b  = b;
    sub      = s;
    carry_in = cin;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    input_a  = 8'hA5;
    input_b  = 8'h5A;
    sub      = ~s;
    carry_in = ~cin;
    lat  = 0;
    lat8 = 0;
    while (!bus2.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus8.out_valid && lat8 == 0) lat8 = lat;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_lat8"}, 32'(lat8), 32'd1);
    check({tag, "_ans"}, 32'(bus2.answer), 32'(ea));
    check({tag, "_carry"}, 32'(bus2.carry), 32'(ec));
    check({tag, "_ovf"}, 32'(bus2.overflow), 32'(ev));
    check({tag, "_ans8"}, 32'(bus8.answer), 32'(ea));
    check({tag, "_carry8"}, 32'(bus8.carry), 32'(ec));
    check({tag, "_ovf8"}, 32'(bus8.overflow), 32'(ev));
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra, rb, ea;
    logic       rs, rc, ec, ev;
    int         lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    input_a   = '0;
    input_b   = '0;
    sub       = 1'b0;
    carry_in  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(bus2.out_valid), 32'd0);
    check("rst_answer", 32'(bus2.answer), 32'd0);
    check("rst_carry", 32'(bus2.carry), 32'd0);
    check("rst_ovf", 32'(bus2.overflow), 32'd0);
    check("rst_in_ready", 32'(bus2.in_ready), 32'd1);

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("add_ff_01c", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("sub_05_05b", 8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("add_7f_00c", 8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);

    // backpressure: 0x44+0x44 held in DONE, then back-to-back accept
    @(negedge clk);
    in_valid = 1'b1;
    input_a  = 8'h44;
    input_b  = 8'h44;
    sub      = 1'b0;
    carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_ans", 32'(bus2.answer), 32'h88);
      check("bp_hold_carry", 32'(bus2.carry), 32'd0);
      check("bp_hold_ovf", 32'(bus2.overflow), 32'd1);
      check("bp_in_ready", 32'(bus2.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus2.out_valid), 32'd1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    input_a   = 8'h01;
    input_b   = 8'h02;
    #1;
    check("bp_in_ready_ack", 32'(bus2.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_ov_drop", 32'(bus2.out_valid), 32'd0);
    lat = 0;
    while (!bus2.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp2_lat", 32'(lat), 32'd4);
    check("bp2_ans", 32'(bus2.answer), 32'h03);
    check("bp2_carry", 32'(bus2.carry), 32'd0);
    consume("bp2");

    // reset during the second RUN cycle
    @(negedge clk);
    in_valid = 1'b1;
    input_a  = 8'h77;
    input_b  = 8'h11;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(bus2.out_valid), 32'd0);
    check("abort_answer", 32'(bus2.answer), 32'd0);
    check("abort_in_ready", 32'(bus2.in_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus2.out_valid) lat++;
    end
    check("abort_no_result", 32'(lat), 32'd0);
    run_op("post_abort", 8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rs, rc, ea, ec, ev);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, rc, ea, ec, ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
